// File: rtl/fcpu_cram_loader.sv
// Serial boot loader for the fcpu code RAM: 'L' frames write little-endian words, 'H'/'R' hold/release the core.
// Optional build macro FCPU_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte per load frame.
`timescale 1ns/1ps
module fcpu_cram_loader #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 32,
   parameter int BOOT_RUN = 0
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   input  logic [ADDR_W-1:0] core_addr,
   output logic              core_hold,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy
);

   localparam int BYTES = DATA_W / 8;
   localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR0,
      S_ADDR1,
      S_CNT0,
      S_CNT1,
      S_DATA,
`ifdef FCPU_LOADER_CHECKSUM_EN
      S_CSUM,
`endif
      S_ACK
   } state_t;

`ifdef FCPU_LOADER_CHECKSUM_EN
   localparam state_t AFTER_DATA = S_CSUM;
`else
   localparam state_t AFTER_DATA = S_ACK;
`endif

   state_t              r_state;
   state_t              w_next;
   logic                r_hold;
   logic [ADDR_W-1:0]   r_addr;
   logic [15:0]         r_cnt;
   logic [7:0]          r_lo;
   logic [BC_W-1:0]     r_bcnt;
   logic [DATA_W-1:0]   r_word;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic                r_tx_valid;
   logic [7:0]          r_tx_data;
`ifdef FCPU_LOADER_CHECKSUM_EN
   logic [7:0]          r_csum;
`endif

   logic                w_accept;
   logic                w_last_byte;
   logic [15:0]         w_pair;
   logic [DATA_W-1:0]   w_word;
   logic [7:0]          w_resp;

   assign w_accept    = rx_valid && (r_state != S_ACK);
   assign w_last_byte = (r_bcnt == BC_W'(BYTES - 1));
   assign w_pair      = {rx_data, r_lo};

   // Bytes shift in from the top so the first byte of a word ends up in bits [7:0].
   generate
      if (BYTES > 1) begin : g_multi
         assign w_word = {rx_data, r_word[DATA_W-1:8]};
      end else begin : g_single
         assign w_word = rx_data;
      end
   endgenerate

`ifdef FCPU_LOADER_CHECKSUM_EN
   assign w_resp = ((r_state == S_CSUM) && (rx_data != r_csum)) ? 8'h15 : 8'h06;
`else
   assign w_resp = 8'h06;
`endif

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (rx_data)
                  8'h4C:        w_next = S_ADDR0;
                  8'h48, 8'h52: w_next = S_ACK;
                  default:      w_next = S_IDLE;
               endcase
            end
         end
         S_ADDR0: if (w_accept) w_next = S_ADDR1;
         S_ADDR1: if (w_accept) w_next = S_CNT0;
         S_CNT0:  if (w_accept) w_next = S_CNT1;
         S_CNT1:  if (w_accept) w_next = (w_pair == 16'd0) ? AFTER_DATA : S_DATA;
         S_DATA:  if (w_accept && w_last_byte && (r_cnt == 16'd1)) w_next = AFTER_DATA;
`ifdef FCPU_LOADER_CHECKSUM_EN
         S_CSUM:  if (w_accept) w_next = S_ACK;
`endif
         S_ACK:   if (r_tx_valid && tx_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_hold     <= (BOOT_RUN == 0);
         r_addr     <= '0;
         r_cnt      <= '0;
         r_lo       <= '0;
         r_bcnt     <= '0;
         r_word     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_tx_valid <= 1'b0;
         r_tx_data  <= '0;
`ifdef FCPU_LOADER_CHECKSUM_EN
         r_csum     <= '0;
`endif
      end else begin
         r_we <= 1'b0;
         // The load address advances after its write cycle, so mem_addr is valid during mem_we.
         if (r_we) r_addr <= r_addr + 1'b1;
         if (r_tx_valid && tx_ready) r_tx_valid <= 1'b0;
         if (w_accept) begin
            case (r_state)
               S_IDLE: begin
                  if (rx_data == 8'h4C) begin
                     r_hold <= 1'b1;
`ifdef FCPU_LOADER_CHECKSUM_EN
                     r_csum <= '0;
`endif
                  end else if (rx_data == 8'h48) begin
                     r_hold <= 1'b1;
                  end else if (rx_data == 8'h52) begin
                     r_hold <= 1'b0;
                  end
               end
               S_ADDR0: r_lo <= rx_data;
               S_ADDR1: r_addr <= w_pair[ADDR_W-1:0];
               S_CNT0:  r_lo <= rx_data;
               S_CNT1: begin
                  r_cnt  <= w_pair;
                  r_bcnt <= '0;
               end
               S_DATA: begin
                  r_word <= w_word;
`ifdef FCPU_LOADER_CHECKSUM_EN
                  r_csum <= r_csum ^ rx_data;
`endif
                  if (w_last_byte) begin
                     r_we    <= 1'b1;
                     r_wdata <= w_word;
                     r_cnt   <= r_cnt - 16'd1;
                     r_bcnt  <= '0;
                  end else begin
                     r_bcnt <= r_bcnt + 1'b1;
                  end
               end
               default: ;
            endcase
         end
         if ((r_state != S_ACK) && (w_next == S_ACK)) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= w_resp;
         end
      end
   end

   assign rx_ready  = (r_state != S_ACK);
   assign busy      = (r_state != S_IDLE);
   assign core_hold = r_hold;
   assign mem_addr  = r_hold ? r_addr : core_addr;
   assign mem_we    = r_we;
   assign mem_wdata = r_wdata;
   assign tx_valid  = r_tx_valid;
   assign tx_data   = r_tx_data;

endmodule

// File: tb/tb_fcpu_cram_loader.sv
// Scoreboard bench for fcpu_cram_loader: stimulus queues expected writes/responses, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_fcpu_cram_loader;

   logic        clk = 1'b0;
   logic        nrst;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  core_addr;
   logic        core_hold;
   logic [7:0]  mem_addr;
   logic        mem_we;
   logic [31:0] mem_wdata;
   logic        busy;

   int vectors = 0;
   int miscompares = 0;
   int gap = 0;

   logic [7:0]  exp_wa_q[$];
   logic [31:0] exp_wd_q[$];
   logic [7:0]  exp_tx_q[$];

   always #5 clk = ~clk;

   fcpu_cram_loader #(.ADDR_W(8), .DATA_W(32), .BOOT_RUN(0)) dut (
      .clk(clk), .nrst(nrst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .core_addr(core_addr), .core_hold(core_hold),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
      .busy(busy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   // Monitor: every write strobe and every response handshake must match the head of its queue.
   always @(negedge clk) begin
      if (nrst === 1'b1) begin
         if (mem_we === 1'b1) begin
            if (exp_wa_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_write: got addr %h data %h, required no write", mem_addr, mem_wdata);
            end else begin
               check("write_addr", mem_addr, exp_wa_q.pop_front());
               check("write_data", mem_wdata, exp_wd_q.pop_front());
               check("write_hold", core_hold, 1);
            end
         end
         if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
            if (exp_tx_q.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected_tx: got %h, required no response", tx_data);
            end else begin
               check("tx_byte", tx_data, exp_tx_q.pop_front());
            end
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int t;
      t = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (rx_ready) break;
         t++;
         if (t > 200) begin
            vectors++;
            miscompares++;
            $display("FAIL rx_timeout: got rx_ready 0 for byte %h, required 1", b);
            break;
         end
      end
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while ((busy || exp_tx_q.size() != 0) && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (t >= 300) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: got busy %0d pending %0d, required idle", busy, exp_tx_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input logic [15:0] a, input int n, input logic [31:0] w0,
                        input logic [31:0] w1, input logic [7:0] resp);
      logic [31:0] w;
      logic [7:0]  ad;
      logic [15:0] n16;
      ad  = a[7:0];
      n16 = n[15:0];
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? w0 : w1;
         exp_wa_q.push_back(ad);
         exp_wd_q.push_back(w);
         ad = ad + 8'd1;
      end
      exp_tx_q.push_back(resp);
      send(8'h4C);
      check("hold_after_L", core_hold, 1);
      send(a[7:0]);
      send(a[15:8]);
      send(n16[7:0]);
      send(n16[15:8]);
      for (int i = 0; i < n; i++) begin
         w = (i == 0) ? w0 : w1;
         for (int j = 0; j < 4; j++) send(w[8*j +: 8]);
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      nrst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1; core_addr = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      check("rst_core_hold", core_hold, 1);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_mem_we", mem_we, 0);
      check("rst_busy", busy, 0);
      check("rst_rx_ready", rx_ready, 1);
      check("rst_mem_addr", mem_addr, 8'h00);
      nrst = 1'b1;
      @(posedge clk);
      #1;

      // Release the core, then the address mux must follow the fetch address.
      exp_tx_q.push_back(8'h06);
      send(8'h52);
      check("hold_after_R", core_hold, 0);
      wait_idle();
      core_addr = 8'hA7;
      #1;
      check("mux_core", mem_addr, 8'hA7);

      // Basic two-word load while the core is running.
      frame(16'h0003, 2, 32'h04200007, 32'h04400008, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h6F);
`endif
      wait_idle();
      check("hold_after_load", core_hold, 1);
      check("mux_hold", mem_addr, 8'h05);

      // Address wrap; upper address byte is discarded.
      frame(16'h12FF, 2, 32'hDEADBEEF, 32'h01020304, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h26);
`endif
      wait_idle();

      // Command values as data, plus a stalled ACK.
      tx_ready = 1'b0;
      frame(16'h0010, 1, 32'h0052484C, 32'h0, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h56);
`endif
      begin
         int t;
         t = 0;
         while (!tx_valid && t < 50) begin
            @(negedge clk);
            t++;
         end
      end
      rx_data = 8'h48;
      rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("stall_tx_valid", tx_valid, 1);
         check("stall_tx_data", tx_data, 8'h06);
         check("stall_rx_ready", rx_ready, 0);
      end
      @(posedge clk);
      #1;
      exp_tx_q.push_back(8'h06);
      tx_ready = 1'b1;
      send(8'h48);
      wait_idle();
      check("hold_after_H", core_hold, 1);

      // Gapped stream with stray bytes in IDLE.
      gap = 2;
      send(8'h00);
      send(8'hFF);
      check("stray_idle", busy, 0);
      frame(16'h0003, 2, 32'h04200007, 32'h04400008, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h6F);
`endif
      wait_idle();

      // Reset in the middle of the second word: only the first word lands.
      exp_wa_q.push_back(8'h20);
      exp_wd_q.push_back(32'h44332211);
      send(8'h4C); send(8'h20); send(8'h00); send(8'h02); send(8'h00);
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      send(8'h55); send(8'h66);
      nrst = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_mem_we", mem_we, 0);
      check("midrst_tx_valid", tx_valid, 0);
      repeat (2) @(posedge clk);
      #1;
      nrst = 1'b1;
      @(posedge clk);
      #1;
      frame(16'h0030, 1, 32'hDDCCBBAA, 32'h0, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      wait_idle();

      // Zero-length load: no writes, address latched.
      gap = 0;
      frame(16'h0050, 0, 32'h0, 32'h0, 8'h06);
`ifdef FCPU_LOADER_CHECKSUM_EN
      send(8'h00);
`endif
      wait_idle();
      check("n0_mem_addr", mem_addr, 8'h50);

`ifdef FCPU_LOADER_CHECKSUM_EN
      frame(16'h0040, 1, 32'h11223344, 32'h0, 8'h06);
      send(8'h44);
      wait_idle();
      frame(16'h0041, 1, 32'h11223344, 32'h0, 8'h15);
      send(8'h45);
      wait_idle();
`endif

      exp_tx_q.push_back(8'h06);
      send(8'h52);
      check("final_release", core_hold, 0);
      wait_idle();
      check("writes_drained", exp_wa_q.size(), 0);
      check("tx_drained", exp_tx_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fcpu_cram_loader.md
Name: fcpu_cram_loader

Overview:
Boot/program-load controller for the fcpu code RAM. Receives a byte stream on the serial input handshake, assembles little-endian DATA_W words and writes them into cram. Arbitrates the cram address port between itself and the core's instruction fetch, and holds the core while loading. Sits in fcpu between the serial block, cram and core.

Parameters:
ADDR_W, 8, cram address width (equals CRAM_ADDR_W at instantiation)
DATA_W, 32, cram word width; must be a multiple of 8 (BYTES = DATA_W/8)
BOOT_RUN, 0, 1 = core released from reset; 0 = core held until 'R' command

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
rx_data  in  8  command/data byte from serial
rx_valid  in  1  rx_data valid
rx_ready  out  1  loader accepts byte
tx_data  out  8  response byte to serial
tx_valid  out  1  response valid
tx_ready  in  1  serial accepts response
core_addr  in  ADDR_W  core fetch address
core_hold  out  1  core stalled; loader owns cram
mem_addr  out  ADDR_W  cram address (muxed)
mem_we  out  1  cram write strobe
mem_wdata  out  DATA_W  cram write data
busy  out  1  state != IDLE

Behaviour:
- One clock (clk); reset asynchronous, active-low (nrst). Reset: state IDLE, core_hold = !BOOT_RUN, tx_valid 0, tx_data 0, mem_we 0, mem_wdata 0, partial word/counters/checksum cleared, busy 0. Reset mid-load abandons the frame; already-written words stay in cram.
- Byte accepted when rx_valid && rx_ready. rx_ready = 1 in every state except ACK.
- States: IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, CSUM (feature only), ACK.
- IDLE: 0x4C 'L' -> core_hold 1 next cycle, go ADDR0. 0x48 'H' -> core_hold 1, go ACK. 0x52 'R' -> core_hold 0, go ACK. Any other byte ignored, stay IDLE, no response.
- ADDR0/ADDR1: start address, low byte first; 16 bits received, low ADDR_W bits kept.
- CNT0/CNT1: 16-bit word count N, low byte first. N = 0 -> skip DATA (go CSUM or ACK).
- DATA: BYTES bytes per word, first byte -> bits [7:0]. On final byte of a word: mem_we = 1 for exactly the next cycle, mem_wdata = assembled word, mem_addr = load address; then address += 1 modulo 2^ADDR_W (wrap 2^ADDR_W-1 -> 0), remaining count -= 1. After last word -> CSUM or ACK.
- mem_addr = core_hold ? load address : core_addr (combinational). mem_we never asserted while core_hold = 0.
- ACK: tx_valid = 1, tx_data = 0x06 (0x15 on checksum failure); held stable until tx_ready; on tx_valid && tx_ready -> tx_valid 0, IDLE. 'L' leaves core_hold at 1 after completion; core resumes only on 'R'.
- 'L', 'H', 'R' values arriving inside a frame are data, not commands.
- 'L' while core running: core_hold rises the cycle after the 'L' byte; earliest write is >= 5 cycles later, so no fetch/write overlap.

Optional Feature:
FCPU_LOADER_CHECKSUM_EN: defined -> after data (or after CNT1 when N = 0) one CSUM byte is received, compared with XOR of all DATA bytes (0x00 for N = 0); match -> 0x06, mismatch -> 0x15. Words are written regardless. Undefined -> no CSUM state, no checksum byte, response always 0x06.

Test Plan:
- Reset with BOOT_RUN=0 -> core_hold 1, tx_valid 0, mem_we 0; send 'R' -> core_hold 0 next cycle, tx 0x06, mem_addr follows core_addr.
- 'L', 03 00, 02 00, 07 00 20 04, 08 00 40 04 -> mem_we pulses at addr 3 data 0x04200007, addr 4 data 0x04400008; tx 0x06; core_hold stays 1.
- ADDR_W=8: load at 0xFF, N=2 -> writes addr 0xFF then 0x00 (wrap).
- tx_ready held 0 for 10 cycles in ACK -> tx_valid/tx_data stable, rx_ready 0; no bytes lost on release.
- rx_valid gaps between every byte plus stray bytes 0x00/0xFF in IDLE -> identical writes, no response to strays; nrst pulse mid-DATA -> IDLE, no further mem_we, next frame loads correctly.
- FCPU_LOADER_CHECKSUM_EN: N=1 word 0x11223344 with csum 0x44 -> 0x06; csum 0x45 -> 0x15; word still written.
